clock_ctrl: RTL and testbench

//   Synthesisable, parametrised clock controller for the CPU datapath. Derives a

---
 rtl/clock_ctrl.sv | 123 ++++++++++++
 tb/tb_clock_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_ctrl.sv
// Clock controller: programmable-rate tick, divided square wave and one-hot phase rotation
// with run / single-step / halt control. Define CLOCK_CTRL_CNT_EN to enable the tick_count counter.
module clock_ctrl #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WIDTH-1:0]    div,
  input  logic                run,
  input  logic                step,
  input  logic                halt,
  output logic                tick,
  output logic                sq,
  output logic [CHANNELS-1:0] phase,
  output logic [CHANNELS-1:0] phase_tick,
  output logic [1:0]          state,
  output logic [CNT_W-1:0]    tick_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    STEP   = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t             state_q, state_n;
  logic [WIDTH-1:0]   cnt, cnt_n;
  logic               tick_n;
  logic               step_q;
  logic               step_edge;

  function automatic logic [CHANNELS-1:0] rotl(input logic [CHANNELS-1:0] v);
    return {v[CHANNELS-2:0], v[CHANNELS-1]};
  endfunction

  assign step_edge = step & ~step_q;

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt;
    tick_n  = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_n = '0;
        if (halt)           state_n = HALTED;
        else if (run)       state_n = RUN;
        else if (step_edge) state_n = STEP;
      end
      RUN: begin
        if (halt) begin
          state_n = HALTED;
          cnt_n   = '0;
        end else if (!run) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt >= div) begin
          cnt_n  = '0;
          tick_n = 1'b1;
        end else begin
          cnt_n = cnt + WIDTH'(1);
        end
      end
      STEP: begin
        // run and further step edges are ignored until the single tick issues
        if (halt) begin
          state_n = HALTED;
          cnt_n   = '0;
        end else if (cnt >= div) begin
          state_n = IDLE;
          cnt_n   = '0;
          tick_n  = 1'b1;
        end else begin
          cnt_n = cnt + WIDTH'(1);
        end
      end
      HALTED: begin
        cnt_n = '0;
        if (!halt) state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt     <= '0;
      tick    <= 1'b0;
      sq      <= 1'b0;
      phase   <= CHANNELS'(1);
      step_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt     <= cnt_n;
      tick    <= tick_n;
      step_q  <= step;
      // sq and phase move on the same edge that raises tick
      if (tick_n) begin
        sq    <= ~sq;
        phase <= rotl(phase);
      end
    end
  end

`ifdef CLOCK_CTRL_CNT_EN
  always_ff @(posedge clk) begin
    if (reset)       tick_count <= '0;
    else if (tick_n) tick_count <= tick_count + CNT_W'(1);
  end
`else
  assign tick_count = '0;
`endif

  assign state      = state_q;
  assign phase_tick = phase & {CHANNELS{tick}};

endmodule

// File: tb/tb_clock_ctrl.sv
// Self-checking bench for clock_ctrl: directed scenarios plus randomized control traffic
// compared against a behavioural model of the controller's rules.
module tb_clock_ctrl;
  localparam int W  = 16;
  localparam int CH = 4;
  localparam int CW = 32;
  localparam int VW = 2 + 2*CH + 2 + CW;

  logic          clk = 1'b0;
  logic          reset, run, step, halt;
  logic [W-1:0]  div;
  logic          tick, sq;
  logic [CH-1:0] phase, phase_tick;
  logic [1:0]    state;
  logic [CW-1:0] tick_count;

  int n_checks = 0;
  int n_fail   = 0;

  // behavioural model: mode uses the numeric values of the state output
  int          m_mode, m_wait, m_ph, m_prev_step;
  bit          m_tick, m_sq;
  longint      m_ticks;

  clock_ctrl #(.WIDTH(W), .CHANNELS(CH), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .div(div), .run(run), .step(step), .halt(halt),
    .tick(tick), .sq(sq), .phase(phase), .phase_tick(phase_tick),
    .state(state), .tick_count(tick_count)
  );

  always #5 clk = ~clk;

  function automatic logic [VW-1:0] exp_vec();
    logic [CH-1:0] ph;
    logic [CW-1:0] tc;
    ph = CH'(1) << m_ph;
`ifdef CLOCK_CTRL_CNT_EN
    tc = CW'(m_ticks);
`else
    tc = '0;
`endif
    return {m_tick, m_sq, ph, ph & {CH{m_tick}}, 2'(m_mode), tc};
  endfunction

  function automatic logic [VW-1:0] obs_vec();
    return {tick, sq, phase, phase_tick, state, tick_count};
  endfunction

  // One clock edge: the model applies the controller rules to the inputs seen at the edge.
  task automatic drive(input bit r, input bit rn, input bit st, input bit h, input int d);
    bit edge_seen, fire;
    reset = r; run = rn; step = st; halt = h; div = W'(d);
    @(posedge clk);
    fire = 0;
    if (r) begin
      m_mode = 0; m_wait = 0; m_ph = 0; m_prev_step = 0; m_sq = 0; m_ticks = 0;
    end else begin
      edge_seen = st && (m_prev_step == 0);
      m_prev_step = st;
      if (h) begin
        m_mode = 3; m_wait = 0;
      end else if (m_mode == 3) begin
        m_mode = 0;
      end else if (m_mode == 0) begin
        if (rn) m_mode = 1;
        else if (edge_seen) m_mode = 2;
        m_wait = 0;
      end else if (m_mode == 1 && !rn) begin
        m_mode = 0; m_wait = 0;
      end else begin
        // RUN or STEP: a tick fires once the wait reaches the live divide value
        if (m_wait >= d) begin
          fire = 1; m_wait = 0;
          if (m_mode == 2) m_mode = 0;
        end else begin
          m_wait++;
        end
      end
      if (fire) begin
        m_sq = !m_sq; m_ph = (m_ph + 1) % CH; m_ticks++;
      end
    end
    m_tick = fire;
    #1;
  endtask

  task automatic test_reset();
    repeat (3) drive(1, 0, 0, 0, 0);
    n_checks++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL reset: got %h expected %h", obs_vec(), exp_vec());
    end
    n_checks++;
    if (phase !== 4'b0001 || state !== 2'd0 || tick !== 1'b0 || sq !== 1'b0 || tick_count !== '0) begin
      n_fail++; $display("FAIL reset_values: tick=%b sq=%b phase=%b state=%0d count=%0d, want 0 0 0001 0 0",
                         tick, sq, phase, state, tick_count);
    end
  endtask

  task automatic test_run();
    int pulses = 0;
    repeat (21) begin
      drive(0, 1, 0, 0, 3);
      if (tick === 1'b1) pulses++;
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL run_div3: got %h expected %h", obs_vec(), exp_vec());
      end
    end
    n_checks++;
    if (pulses != 5) begin
      n_fail++; $display("FAIL run_pulses: got %0d expected 5", pulses);
    end
  endtask

  task automatic test_div0();
    repeat (8) begin
      drive(0, 1, 0, 0, 0);
      n_checks++;
      if (obs_vec() !== exp_vec() || tick !== 1'b1) begin
        n_fail++; $display("FAIL run_div0: got %h expected %h", obs_vec(), exp_vec());
      end
    end
    drive(0, 0, 0, 0, 0);
    n_checks++;
    if (state !== 2'd0 || tick !== 1'b0) begin
      n_fail++; $display("FAIL run_exit: state=%0d tick=%b expected 0 0", state, tick);
    end
  endtask

  task automatic test_step();
    int pulses = 0;
    repeat (10) begin
      drive(0, 0, 1, 0, 2);
      if (tick === 1'b1) pulses++;
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL step_hold: got %h expected %h", obs_vec(), exp_vec());
      end
    end
    n_checks++;
    if (pulses != 1 || state !== 2'd0) begin
      n_fail++; $display("FAIL step_single: pulses=%0d state=%0d expected 1 0", pulses, state);
    end
    drive(0, 0, 0, 0, 2);
    pulses = 0;
    repeat (6) begin
      drive(0, 0, 1, 0, 2);
      if (tick === 1'b1) pulses++;
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL step_second: got %h expected %h", obs_vec(), exp_vec());
      end
    end
    n_checks++;
    if (pulses != 1) begin
      n_fail++; $display("FAIL step_second_pulses: got %0d expected 1", pulses);
    end
    drive(0, 0, 0, 0, 2);
  endtask

  task automatic test_halt();
    int guard = 0;
    drive(0, 1, 0, 0, 5);
    while (m_wait != 5 && guard < 50) begin
      drive(0, 1, 0, 0, 5);
      guard++;
    end
    n_checks++;
    if (guard >= 50) begin
      n_fail++; $display("FAIL halt_setup: wait=%0d expected 5 within 50 cycles", m_wait);
    end
    drive(0, 1, 0, 1, 5);
    n_checks++;
    if (tick !== 1'b0 || state !== 2'd3 || obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL halt_edge: tick=%b state=%0d expected 0 3", tick, state);
    end
    drive(0, 0, 1, 1, 5);
    drive(0, 0, 0, 1, 5);
    n_checks++;
    if (tick !== 1'b0 || state !== 2'd3 || obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL halt_step_ignored: tick=%b state=%0d expected 0 3", tick, state);
    end
    drive(0, 0, 0, 0, 5);
    n_checks++;
    if (state !== 2'd0 || obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL halt_release: state=%0d expected 0", state);
    end
  endtask

  task automatic test_div_change_and_reset();
    int guard = 0;
    drive(0, 1, 0, 0, 7);
    while (m_wait != 5 && guard < 50) begin
      drive(0, 1, 0, 0, 7);
      guard++;
    end
    n_checks++;
    if (guard >= 50) begin
      n_fail++; $display("FAIL divchg_setup: wait=%0d expected 5 within 50 cycles", m_wait);
    end
    drive(0, 1, 0, 0, 1);
    n_checks++;
    if (tick !== 1'b1 || obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL div_lowered: tick=%b expected 1 (got %h expected %h)", tick, obs_vec(), exp_vec());
    end
    drive(0, 0, 0, 0, 5);
    drive(0, 0, 1, 0, 5);
    drive(0, 0, 1, 0, 5);
    drive(0, 0, 1, 0, 5);
    n_checks++;
    if (state !== 2'd2) begin
      n_fail++; $display("FAIL step_entry: state=%0d expected 2", state);
    end
    drive(1, 0, 1, 0, 5);
    n_checks++;
    if (state !== 2'd0 || tick !== 1'b0 || tick_count !== '0 || obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL reset_in_step: state=%0d tick=%b count=%0d expected 0 0 0", state, tick, tick_count);
    end
    drive(0, 0, 0, 0, 5);
  endtask

  task automatic test_random();
    int d;
    bit r, rn, st, h;
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(63) == 0);
      rn = ($urandom_range(3) != 0);
      st = $urandom_range(1);
      h  = ($urandom_range(15) == 0);
      d  = $urandom_range(5);
      drive(r, rn, st, h, d);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL random[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; step = 1'b0; halt = 1'b0; div = '0;
    m_mode = 0; m_wait = 0; m_ph = 0; m_prev_step = 0; m_tick = 0; m_sq = 0; m_ticks = 0;
    test_reset();
    test_run();
    test_div0();
    test_step();
    test_halt();
    test_div_change_and_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
